// File: rtl/wait_state_ram_if.sv
// rtl/wait_state_ram_if.sv - controller-to-RAM request/response bundle
interface wait_state_ram_if;
    logic        Ren;
    logic        Wen;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        busy_o;

    modport master (
        output Ren, Wen, ramaddr, ramstore,
        input  ramload, busy_o
    );

    modport slave (
        input  Ren, Wen, ramaddr, ramstore,
        output ramload, busy_o
    );
endinterface

// File: rtl/wait_state_ram.sv
// rtl/wait_state_ram.sv - word-addressed single-port RAM with programmable wait states
module wait_state_ram #(
    parameter int LAT = 2,
    parameter int AW  = 10
) (
    input  logic            CLK,
    input  logic            nRST,
    wait_state_ram_if.slave bus
);
    localparam int         DEPTH  = 1 << AW;
    localparam logic [3:0] RELOAD = (LAT > 1) ? 4'(LAT - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t          state, state_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic            cap_op, cap_op_nxt;
    logic [AW-1:0]   cap_idx, cap_idx_nxt;
    logic [31:0]     cap_data, cap_data_nxt;
    logic [31:0]     mem [DEPTH];

    logic            req_valid;
    logic            req_op;
    logic [AW-1:0]   req_idx;
    logic            key_match;
    logic            start;
    logic            access;
    logic            unused_addr;

    // Both strobes high is the controller's idle code, so XOR is the request.
    assign req_valid = bus.Ren ^ bus.Wen;
    assign req_op    = bus.Wen;
    assign req_idx   = bus.ramaddr[AW+1:2];
    assign key_match = (req_op == cap_op) && (req_idx == cap_idx) &&
                       (!req_op || (bus.ramstore == cap_data));
    assign bus.busy_o = req_valid && !((state == DONE) && key_match);
    assign unused_addr = &{1'b0, bus.ramaddr[31:AW+2], bus.ramaddr[1:0]};

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        cap_op_nxt   = cap_op;
        cap_idx_nxt  = cap_idx;
        cap_data_nxt = cap_data;
        start        = 1'b0;
        access       = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) start = 1'b1;
            end
            WAIT: begin
                if (!req_valid) begin
                    state_nxt = IDLE;
                end else if (!key_match) begin
                    start = 1'b1;
                end else if (cnt == 4'd0) begin
                    state_nxt = DONE;
                    access    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE: begin
                if (!req_valid) state_nxt = IDLE;
                else if (!key_match) start = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        // Any fresh key restarts the full latency count from this cycle.
        if (start) begin
            cap_op_nxt   = req_op;
            cap_idx_nxt  = req_idx;
            cap_data_nxt = bus.ramstore;
            if (LAT == 1) begin
                state_nxt = DONE;
                access    = 1'b1;
            end else begin
                state_nxt = WAIT;
                cnt_nxt   = RELOAD;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            cap_op      <= 1'b0;
            cap_idx     <= '0;
            cap_data    <= 32'd0;
            bus.ramload <= 32'd0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            cap_op   <= cap_op_nxt;
            cap_idx  <= cap_idx_nxt;
            cap_data <= cap_data_nxt;
            if (access && !req_op) bus.ramload <= mem[req_idx];
        end
    end

    // Array is never reset; gate on nRST so no write lands while held in reset.
    always_ff @(posedge CLK) begin
        if (nRST && access && req_op) mem[req_idx] <= bus.ramstore;
    end
endmodule

// File: doc/wait_state_ram.md
# wait_state_ram

Word-addressed single-port RAM with programmable access latency. It sits directly downstream of the memory controller: it consumes `Ren`, `Wen`, `ramaddr` and `ramstore`, and returns `ramload` and `busy_o`. It stalls every access for a fixed number of wait states, so the controller's instruction/data wait and ready logic is exercised exactly as it will be against real memory.

## Interface
- `LAT`, default 2: cycles `busy_o` stays high per access; legal range 1..15.
- `AW`, default 10: word-index width; `DEPTH` = 2^AW 32-bit words.
- `CLK` in 1: system clock; all state updates on the rising edge.
- `nRST` in 1: reset, asynchronous, active-low.
- `Ren` in 1: read request.
- `Wen` in 1: write request.
- `ramaddr` in 32: byte address. Word index = `ramaddr[AW+1:2]`; bits [1:0] and bits above AW+1 are ignored.
- `ramstore` in 32: write data.
- `ramload` out 32: read data, registered.
- `busy_o` out 1: access in progress. Low together with a live request means the access is complete and `ramload` is valid.

## Operation
- Valid request: exactly one of `Ren`/`Wen` is high. Both low, or both high (the controller's idle encoding), is no request.
- Request key: {op, word index}, plus `ramstore` for writes. The key is captured at each accepted start.
- States:
  - IDLE
  - WAIT: down-counter `cnt`, 4 bits
  - DONE
- IDLE:
  - Valid request: capture key. If LAT=1, go to DONE; otherwise go to WAIT with `cnt` = LAT-2.
  - No request: stay in IDLE.
- WAIT:
  - Request absent: go to IDLE. The access is aborted and no write is performed.
  - Request key differs from captured key: recapture the key and reload `cnt` = LAT-2, or go to DONE if LAT=1. The aborted access has no effect.
  - Otherwise, `cnt`==0: go to DONE. Otherwise decrement `cnt`.
- Entry into DONE (the same clock edge):
  - Write: `mem[idx]` <= captured data.
  - Read: `ramload` <= `mem[idx]`.
- DONE:
  - Matching request held: stay in DONE; `ramload` is stable and no further write occurs.
  - Request absent: go to IDLE.
  - Key differs: restart as from IDLE.
- `busy_o` (combinational) = valid request AND NOT (state==DONE AND key matches captured key).
- `ramload` holds its last read value across writes, idle cycles and aborts.
- A read of a word returns the value of the most recently completed write to that word, including a write completed on the immediately preceding edge.
- Array contents are not cleared by reset and are retained across `nRST` assertion.

## Timing
- Reset values: state=IDLE, `cnt`=0, captured key=0, `ramload`=0. `busy_o` follows its combinational equation: high if a valid request is present during reset, else 0.
- A request first presented in cycle 0 and held unchanged gives:
  - `busy_o` = 1 in cycles 0..LAT-1.
  - `busy_o` = 0 from cycle LAT onward.
  - Read data valid on `ramload` from cycle LAT.
  - Write committed at the edge ending cycle LAT-1.
- Back-to-back accesses: a new key presented in the cycle after completion gives another LAT busy cycles. There is no extra idle cycle.
- A key change at any cycle restarts the full LAT count from that cycle.
- Reset mid-WAIT: the access is aborted with no write, and `ramload` is cleared to 0.

## Test plan
- LAT=2, read of word 4 (preloaded 0xDEADBEEF) held from cycle 0 -> `busy_o` = 1,1,0; `ramload` = 0xDEADBEEF in cycle 2 and stable while the request is held.
- LAT=3, write 0x12345678 to 0x10, then a read of 0x10 immediately after -> write `busy_o` high for 3 cycles; read `busy_o` high for 3 cycles; `ramload` = 0x12345678.
- LAT=3, read of 0x20 changed to 0x24 in cycle 1 -> `busy_o` high in cycles 0..3; `ramload` = `mem[9]` in cycle 4; `mem[8]` is never returned.
- LAT=2, write 0xAAAA5555 to 0x8 dropped to `Ren`=`Wen`=1 in cycle 1, then a read of 0x8 -> old contents returned; `busy_o` = 0 while the idle code is present.
- LAT=1, alternating read/write stream to 0x0/0x4 -> each access has exactly 1 busy cycle; data is correct on every read.
- LAT=4, `nRST` pulsed low in cycle 2 of a write of 0x77 to 0xC -> `ramload`=0 and state IDLE; a subsequent read of 0xC returns the pre-write value.
